cv32e40p_instr_aligner: RTL and testbench

Sits directly downstream of the prefetch buffer, between it and the IF/ID pipeline register. It consumes word-aligned 32-bit fetch words and emits one instruction at a time: either a full 32-bit instruction or a zero-extended 16-bit RV32C instruction, each with its PC. It handles 32-bit instructions that straddle two fetch words, and branch or hardware-loop targets at half-word offsets.

---
 rtl/cv32e40p_instr_aligner.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_instr_aligner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_aligner.sv
// Instruction aligner: turns word-aligned 32-bit fetch words into single RV32I/RV32C
// instructions with their PCs, including instructions that straddle two fetch words.
module cv32e40p_instr_aligner (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_aligned_o,
   output logic        instr_compressed_o,
   output logic [31:0] pc_o,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        hwlp_jump_i,
   input  logic [31:0] hwlp_target_i
);

   localparam logic [1:0] ALIGNED           = 2'd0;
   localparam logic [1:0] MISALIGNED32      = 2'd1;
   localparam logic [1:0] MISALIGNED16      = 2'd2;
   localparam logic [1:0] BRANCH_MISALIGNED = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] hword_q, hword_d;

   logic [15:0] rdata_lo, rdata_hi;
   logic        lo_is_c, hi_is_c;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc_plus2, pc_plus4;

   assign rdata_lo        = fetch_rdata_i[15:0];
   assign rdata_hi        = fetch_rdata_i[31:16];
   assign lo_is_c         = (rdata_lo[1:0] != 2'b11);
   assign hi_is_c         = (rdata_hi[1:0] != 2'b11);
   assign redirect        = branch_i | hwlp_jump_i;
   assign redirect_target = branch_i ? branch_addr_i : hwlp_target_i;
   assign pc_plus2        = pc_q + 32'd2;
   assign pc_plus4        = pc_q + 32'd4;
   assign pc_o            = pc_q;

   always_comb begin
      // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
      state_d            = state_q;
      pc_d               = pc_q;
      hword_d            = hword_q;
      instr_valid_o      = 1'b0;
      fetch_ready_o      = 1'b0;
      instr_aligned_o    = fetch_rdata_i;
      instr_compressed_o = 1'b0;

      case (state_q)
         ALIGNED: begin
            instr_valid_o = fetch_valid_i;
            if (lo_is_c) begin
               instr_aligned_o    = {16'h0000, rdata_lo};
               instr_compressed_o = 1'b1;
               if (fetch_valid_i && instr_ready_i) begin
                  fetch_ready_o = 1'b1;
                  pc_d          = pc_plus2;
                  hword_d       = rdata_hi;
                  state_d       = hi_is_c ? MISALIGNED16 : MISALIGNED32;
               end
            end else begin
               instr_aligned_o = fetch_rdata_i;
               if (fetch_valid_i && instr_ready_i) begin
                  fetch_ready_o = 1'b1;
                  pc_d          = pc_plus4;
               end
            end
         end

         MISALIGNED32: begin
            instr_valid_o   = fetch_valid_i;
            instr_aligned_o = {rdata_lo, hword_q};
            if (fetch_valid_i && instr_ready_i) begin
               fetch_ready_o = 1'b1;
               pc_d          = pc_plus4;
               hword_d       = rdata_hi;
               state_d       = hi_is_c ? MISALIGNED16 : MISALIGNED32;
            end
         end

         MISALIGNED16: begin
            // The buffered half-word is a complete instruction; no fetch word is needed.
            instr_valid_o      = 1'b1;
            instr_aligned_o    = {16'h0000, hword_q};
            instr_compressed_o = 1'b1;
            if (instr_ready_i) begin
               pc_d    = pc_plus2;
               state_d = ALIGNED;
            end
         end

         BRANCH_MISALIGNED: begin
            if (fetch_valid_i) begin
               if (hi_is_c) begin
                  instr_valid_o      = 1'b1;
                  instr_aligned_o    = {16'h0000, rdata_hi};
                  instr_compressed_o = 1'b1;
                  if (instr_ready_i) begin
                     fetch_ready_o = 1'b1;
                     pc_d          = pc_plus2;
                     state_d       = ALIGNED;
                  end
               end else begin
                  // First half of a straddling target: swallow the word and wait for the rest.
                  fetch_ready_o = 1'b1;
                  hword_d       = rdata_hi;
                  state_d       = MISALIGNED32;
               end
            end
         end

         default: begin
            state_d = ALIGNED;
         end
      endcase

      if (redirect) begin
         instr_valid_o = 1'b0;
         fetch_ready_o = 1'b0;
         pc_d          = redirect_target;
         hword_d       = hword_q;
         state_d       = redirect_target[1] ? BRANCH_MISALIGNED : ALIGNED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ALIGNED;
         pc_q    <= 32'h0000_0000;
         hword_q <= 16'h0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state_q <= state_d;
         pc_q    <= pc_d;
         hword_q <= hword_d;
      end
   end

   a_ready_implies_valid : assert property (@(posedge clk) disable iff (!rst_n)
      fetch_ready_o |-> fetch_valid_i);
   a_no_issue_on_redirect : assert property (@(posedge clk) disable iff (!rst_n)
      redirect |-> (!instr_valid_o && !fetch_ready_o));

endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// Scoreboard bench for the instruction aligner: stimulus pushes expected issues,
// a negedge monitor pops and compares them whenever an instruction is accepted.
module tb_cv32e40p_instr_aligner;

   typedef struct {
      logic [31:0] instr;
      logic        comp;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic [31:0] fetch_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_aligned_o;
   logic        instr_compressed_o;
   logic [31:0] pc_o;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        hwlp_jump_i;
   logic [31:0] hwlp_target_i;

   exp_t        exp_q[$];
   logic [31:0] fq[$];
   int          n_vec;
   int          n_miss;
   int          pop_cnt;
   logic        pop_seen;

   cv32e40p_instr_aligner dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .fetch_valid_i      (fetch_valid_i),
      .fetch_ready_o      (fetch_ready_o),
      .fetch_rdata_i      (fetch_rdata_i),
      .instr_valid_o      (instr_valid_o),
      .instr_ready_i      (instr_ready_i),
      .instr_aligned_o    (instr_aligned_o),
      .instr_compressed_o (instr_compressed_o),
      .pc_o               (pc_o),
      .branch_i           (branch_i),
      .branch_addr_i      (branch_addr_i),
      .hwlp_jump_i        (hwlp_jump_i),
      .hwlp_target_i      (hwlp_target_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_issue(input logic [31:0] instr, input logic comp, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.comp  = comp;
      e.pc    = pc;
      exp_q.push_back(e);
   endtask

   task automatic drive_fetch();
      fetch_valid_i = (fq.size() != 0);
      fetch_rdata_i = (fq.size() != 0) ? fq[0] : 32'h0;
   endtask

   // Advance one cycle, retiring the fetch word the DUT consumed at this edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (pop_seen && fq.size() != 0) void'(fq.pop_front());
      drive_fetch();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain_timeout: %0d issues still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic redirect(input logic br, input logic hw, input logic [31:0] ba, input logic [31:0] ha);
      branch_i      = br;
      hwlp_jump_i   = hw;
      branch_addr_i = ba;
      hwlp_target_i = ha;
      step();
      branch_i    = 1'b0;
      hwlp_jump_i = 1'b0;
      fq.delete();
      drive_fetch();
      check("redirect_pc", pc_o, br ? ba : ha);
   endtask

   always @(negedge clk) begin
      exp_t e;
      pop_seen = fetch_valid_i && fetch_ready_o;
      if (pop_seen) pop_cnt++;
      if (rst_n) begin
         if (fetch_ready_o && !fetch_valid_i)
            check("ready_without_valid", {31'b0, fetch_ready_o}, 32'h0);
         if (branch_i || hwlp_jump_i) begin
            check("redirect_valid", {31'b0, instr_valid_o}, 32'h0);
            check("redirect_ready", {31'b0, fetch_ready_o}, 32'h0);
         end else if (instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_issue: got %h at pc %h, expected none", instr_aligned_o, pc_o);
            end else begin
               e = exp_q.pop_front();
               check("issue_instr", instr_aligned_o, e.instr);
               check("issue_comp", {31'b0, instr_compressed_o}, {31'b0, e.comp});
               check("issue_pc", pc_o, e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      n_vec = 0; n_miss = 0; pop_cnt = 0; pop_seen = 1'b0;
      rst_n = 1'b0;
      fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; instr_ready_i = 1'b1;
      branch_i = 1'b0; branch_addr_i = 32'h0; hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", {31'b0, instr_valid_o}, 32'h0);
      check("reset_ready", {31'b0, fetch_ready_o}, 32'h0);
      check("reset_pc", pc_o, 32'h0);
      rst_n = 1'b1;
      step();

      // Aligned 32-bit pair.
      redirect(1'b1, 1'b0, 32'h100, 32'h0);
      fq.push_back(32'h0000_0013); fq.push_back(32'h0010_0093); drive_fetch();
      expect_issue(32'h0000_0013, 1'b0, 32'h100);
      expect_issue(32'h0010_0093, 1'b0, 32'h104);
      p0 = pop_cnt;
      drain(20);
      check("aligned_pops", pop_cnt - p0, 2);

      // Two compressed instructions in one word; the second does not pop.
      redirect(1'b1, 1'b0, 32'h200, 32'h0);
      fq.push_back(32'h0001_0001); drive_fetch();
      expect_issue(32'h0000_0001, 1'b1, 32'h200);
      expect_issue(32'h0000_0001, 1'b1, 32'h202);
      p0 = pop_cnt;
      drain(20);
      check("c16_pops", pop_cnt - p0, 1);

      // Straddling 32-bit instruction, then the buffered 0x1234 half-word issues as compressed.
      redirect(1'b1, 1'b0, 32'h300, 32'h0);
      fq.push_back(32'h0093_0001); fq.push_back(32'h1234_0010); drive_fetch();
      expect_issue(32'h0000_0001, 1'b1, 32'h300);
      expect_issue(32'h0010_0093, 1'b0, 32'h302);
      expect_issue(32'h0000_1234, 1'b1, 32'h306);
      p0 = pop_cnt;
      drain(20);
      check("straddle_pops", pop_cnt - p0, 2);

      // Misaligned 32-bit branch target.
      redirect(1'b1, 1'b0, 32'h402, 32'h0);
      fq.push_back(32'h0013_FFFF); fq.push_back(32'h0000_0000); drive_fetch();
      expect_issue(32'h0000_0013, 1'b0, 32'h402);
      expect_issue(32'h0000_0000, 1'b1, 32'h406);
      p0 = pop_cnt;
      drain(20);
      check("brmis32_pops", pop_cnt - p0, 2);

      // Misaligned compressed branch target.
      redirect(1'b1, 1'b0, 32'h802, 32'h0);
      fq.push_back(32'h0005_FFFF); drive_fetch();
      expect_issue(32'h0000_0005, 1'b1, 32'h802);
      p0 = pop_cnt;
      drain(20);
      check("brmis16_pops", pop_cnt - p0, 1);

      // Stall, then simultaneous branch and hwlp redirect.
      redirect(1'b1, 1'b0, 32'h900, 32'h0);
      instr_ready_i = 1'b0;
      fq.push_back(32'h0010_0093); drive_fetch();
      p0 = pop_cnt;
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", {31'b0, instr_valid_o}, 32'h1);
         check("stall_instr", instr_aligned_o, 32'h0010_0093);
         check("stall_comp", {31'b0, instr_compressed_o}, 32'h0);
         check("stall_pc", pc_o, 32'h900);
         step();
      end
      check("stall_pops", pop_cnt - p0, 0);
      instr_ready_i = 1'b1;
      redirect(1'b1, 1'b1, 32'h500, 32'h600);
      fq.push_back(32'h0000_0013); drive_fetch();
      expect_issue(32'h0000_0013, 1'b0, 32'h500);
      drain(20);

      // Hardware-loop redirect alone.
      redirect(1'b0, 1'b1, 32'hDEAD_0000, 32'h600);
      fq.push_back(32'h0000_0013); drive_fetch();
      expect_issue(32'h0000_0013, 1'b0, 32'h600);
      drain(20);

      // PC wraps past 2^32.
      redirect(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
      fq.push_back(32'h0001_0001); fq.push_back(32'h0000_0013); drive_fetch();
      expect_issue(32'h0000_0001, 1'b1, 32'hFFFF_FFFC);
      expect_issue(32'h0000_0001, 1'b1, 32'hFFFF_FFFE);
      expect_issue(32'h0000_0013, 1'b0, 32'h0000_0000);
      drain(20);

      // Async reset while in MISALIGNED32 loses the buffered half-word.
      redirect(1'b1, 1'b0, 32'h700, 32'h0);
      fq.push_back(32'h0013_0001); drive_fetch();
      expect_issue(32'h0000_0001, 1'b1, 32'h700);
      drain(20);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'b0, instr_valid_o}, 32'h0);
      check("midrst_ready", {31'b0, fetch_ready_o}, 32'h0);
      check("midrst_pc", pc_o, 32'h0);
      step();
      rst_n = 1'b1;
      fq.push_back(32'h0000_0013); drive_fetch();
      expect_issue(32'h0000_0013, 1'b0, 32'h0);
      drain(20);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
